// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, reset PC and the fetch entry record shared by the
// fetch and decode stages.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 11;
  localparam int INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

  // One fetched instruction together with the word address it came from.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^ADDR_WIDTH by construction.
  function automatic logic [ADDR_WIDTH-1:0] pc_next(input logic [ADDR_WIDTH-1:0] pc);
    return pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry synchronous buffer of {pc, instruction} pairs with
// push, pop and flush. A push and a pop in the same cycle are allowed at any
// occupancy, including full, because the popped slot is reused.
module fetch_fifo #(
  parameter int ADDR_WIDTH  = 11,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instruction,
  input  logic                   pop,
  input  logic                   flush,
  output logic [1:0]             count,
  output logic                   head_valid,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [INSTR_WIDTH-1:0] head_instruction
);

  logic [ADDR_WIDTH-1:0]  pc_mem    [2];
  logic [INSTR_WIDTH-1:0] instr_mem [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic                   do_pop;
  logic                   do_push;

  assign head_valid = (count != 2'd0);
  assign do_pop     = pop && head_valid;
  assign do_push    = push && !flush && ((count != 2'd2) || do_pop);

  // The write slot is the one just behind the live entries; when full and
  // popping, that is the slot being vacated by the head.
  assign wr_ptr = rd_ptr ^ count[0];

  // Storage write for accepted pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mem[0]    <= '0;
      pc_mem[1]    <= '0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
    end else if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instruction;
    end
  end

  // Read pointer and occupancy; flush drops everything and re-aligns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_pc          = head_valid ? pc_mem[rd_ptr]    : '0;
  assign head_instruction = head_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, drives the instruction memory
// address, and queues returned words for decode. A redirect reloads the PC
// and flushes the queue; a head accepted in the same cycle still counts.
module fetch_unit #(
  parameter int                         ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int                         INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = cpu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instraction,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            count;
  logic                  pop;
  logic                  fetch;

  assign imem_address = pc;
  assign pop          = out_valid && out_ready;

  // A slot is free if the buffer is not full or the head leaves this cycle.
  assign fetch = !redirect_valid && ((count != 2'd2) || pop);

  // Program counter: redirect wins, otherwise advance only on a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (fetch) begin
      pc <= pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  fetch_fifo #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push             (fetch),
    .push_pc          (pc),
    .push_instruction (imem_instraction),
    .pop              (pop),
    .flush            (redirect_valid),
    .count            (count),
    .head_valid       (out_valid),
    .head_pc          (out_pc),
    .head_instruction (out_instruction)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] imem_address;
  logic [31:0] imem_instraction;
  logic        redirect_valid;
  logic [10:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [10:0] out_pc;

  logic [31:0] mem [0:2047];

  int total = 0;
  int bad   = 0;

  fetch_entry_t mq[$];
  logic [10:0]  mpc;
  fetch_entry_t delivered[$];

  always #5 clk = ~clk;

  assign imem_instraction = mem[imem_address];

  fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_address     (imem_address),
    .imem_instraction (imem_instraction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mpc = 11'd0;
  endtask

  task automatic checkModel();
    logic [31:0] ep;
    logic [31:0] ei;
    logic        ev;
    ev = (mq.size() > 0);
    ep = ev ? 32'(mq[0].pc) : 32'd0;
    ei = ev ? mq[0].instruction : 32'd0;
    checkOutput("imem_address", 32'(imem_address), 32'(mpc));
    checkOutput("out_valid", 32'(out_valid), 32'(ev));
    checkOutput("out_pc", 32'(out_pc), ep);
    checkOutput("out_instruction", out_instruction, ei);
  endtask

  // Called at a falling edge: drive, check, then advance the model over the
  // coming rising edge, and return at the next falling edge.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [10:0] target);
    fetch_entry_t e;
    out_ready       = ready;
    redirect_valid  = redir;
    redirect_target = target;
    #1;
    checkModel();
    if (out_valid && out_ready) begin
      e.pc          = out_pc;
      e.instruction = out_instruction;
      delivered.push_back(e);
    end
    if (rst_n) begin
      if (ready && mq.size() > 0) void'(mq.pop_front());
      if (redir) begin
        mq.delete();
        mpc = target;
      end else if (mq.size() < 2) begin
        e.pc          = mpc;
        e.instruction = mem[mpc];
        mq.push_back(e);
        mpc = 11'((int'(mpc) + 1) % 2048);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n6;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[0] = 32'h8D40_0000;
    mem[1] = 32'h8D41_0001;
    mem[2] = 32'h0001_1020;

    rst_n           = 1'b1;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 11'd0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_imem_address", 32'(imem_address), 32'h000);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", 32'(out_pc), 32'd0);
    checkOutput("rst_out_instruction", out_instruction, 32'd0);
    modelReset();
    rst_n = 1'b1;

    $display("[TB] free run");
    delivered.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 11'd0);
    checkOutput("free_count", 32'(delivered.size()), 32'd3);
    if (delivered.size() == 3) begin
      checkOutput("free_pc0", 32'(delivered[0].pc), 32'd0);
      checkOutput("free_pc1", 32'(delivered[1].pc), 32'd1);
      checkOutput("free_pc2", 32'(delivered[2].pc), 32'd2);
      checkOutput("free_in0", delivered[0].instruction, 32'h8D40_0000);
      checkOutput("free_in1", delivered[1].instruction, 32'h8D41_0001);
      checkOutput("free_in2", delivered[2].instruction, 32'h0001_1020);
    end

    $display("[TB] backpressure from reset");
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 11'd0);
    checkOutput("bp_imem_address", 32'(imem_address), 32'h002);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_head_pc", 32'(out_pc), 32'd0);
    checkOutput("bp_head_instruction", out_instruction, 32'h8D40_0000);
    delivered.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 11'd0);
    checkOutput("bp_count", 32'(delivered.size()), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < delivered.size()) checkOutput("bp_order", 32'(delivered[i].pc), 32'(i));
    end

    $display("[TB] redirect with full buffer");
    applyStimulus(1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b1, 11'h040);
    checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
    checkOutput("redir_imem_address", 32'(imem_address), 32'h040);
    applyStimulus(1'b0, 1'b0, 11'd0);
    checkOutput("redir_out_pc", 32'(out_pc), 32'h040);

    $display("[TB] redirect with simultaneous pop");
    applyStimulus(1'b0, 1'b1, 11'h005);
    applyStimulus(1'b0, 1'b0, 11'd0);
    checkOutput("rp_head_pc", 32'(out_pc), 32'h005);
    delivered.delete();
    applyStimulus(1'b1, 1'b1, 11'h010);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 11'd0);
    checkOutput("rp_count", 32'(delivered.size()), 32'd3);
    if (delivered.size() >= 2) begin
      checkOutput("rp_first", 32'(delivered[0].pc), 32'h005);
      checkOutput("rp_second", 32'(delivered[1].pc), 32'h010);
    end
    n6 = 0;
    foreach (delivered[i]) if (delivered[i].pc == 11'h006) n6++;
    checkOutput("rp_no_pc6", 32'(n6), 32'd0);

    $display("[TB] wrap");
    applyStimulus(1'b1, 1'b1, 11'h7FF);
    delivered.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 11'd0);
    checkOutput("wrap_count", 32'(delivered.size()), 32'd2);
    if (delivered.size() == 2) begin
      checkOutput("wrap_first", 32'(delivered[0].pc), 32'h7FF);
      checkOutput("wrap_second", 32'(delivered[1].pc), 32'h000);
    end

    $display("[TB] asynchronous reset between edges");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_imem_address", 32'(imem_address), 32'h000);
    checkModel();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    11'($urandom_range(0, 2047)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
